// File: rtl/scaler_linear_v.sv
// Vertical linear scaler. One line buffer holds the previous input line.
// Each emitted output line blends the previous and current input lines with
// weights derived from the fractional output position. Latency is 3 clk.
module scaler_linear_v #(
    parameter int PIXEL_STEP    = 4096,
    parameter int PIXEL_WIDTH   = 12,
    parameter int COE_WIDTH     = 10,
    parameter int LINE_SIZE_MAX = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            v_scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o
);
    localparam int STEP_LOG2 = $clog2(PIXEL_STEP);
    localparam int COE_SHIFT = STEP_LOG2 - COE_WIDTH + 1;
    localparam int ADDR_W    = $clog2(LINE_SIZE_MAX);
    localparam int X_W       = ADDR_W + 1;
    localparam int DY_W      = STEP_LOG2 + 1;
    localparam int POS_W     = 32;
    localparam int LINE_W    = POS_W - STEP_LOG2;
    localparam int PROD_W    = COE_WIDTH + PIXEL_WIDTH;
    localparam int SUM_W     = PROD_W + 1;

    localparam logic [COE_WIDTH-1:0]   UNITY    = COE_WIDTH'(2 ** (COE_WIDTH - 1));
    localparam logic [SUM_W-1:0]       ROUND    = SUM_W'(2 ** (COE_WIDTH - 2));
    localparam logic [POS_W-1:0]       STEP_POS = POS_W'(PIXEL_STEP);
    localparam logic [15:0]            STEP_MIN = 16'(PIXEL_STEP);
    localparam logic [X_W-1:0]         X_LIMIT  = X_W'(LINE_SIZE_MAX);
    localparam logic [PIXEL_WIDTH-1:0] PIX_MAX  = {PIXEL_WIDTH{1'b1}};

    typedef enum logic {WAIT_FRAME, ACTIVE} state_t;

    // Line-tracking state
    state_t                 state_q, state_d;
    logic [X_W-1:0]         x_q, x_d;
    logic [LINE_W-1:0]      line_q, line_d;
    logic [POS_W-1:0]       yo_q, yo_d;
    logic [15:0]            step_q, step_d;
    logic                   pending_q, pending_d;
    logic                   emit_q, emit_d;
    logic [DY_W-1:0]        dy_q, dy_d;

    // Stage 1: captured pixel plus blend coefficient
    logic                   v1_q, v1_d, hs1_q, hs1_d, vs1_q, vs1_d;
    logic [PIXEL_WIDTH-1:0] cur1_q, cur1_d;
    logic [COE_WIDTH-1:0]   ccur1_q, ccur1_d;

    // Stage 2: weighted sum
    logic                   v2_q, v2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    logic [SUM_W-1:0]       sum2_q, sum2_d;

    // Stage 3: clamped output
    logic [PIXEL_WIDTH-1:0] do_q, do_d;
    logic                   de_q, de_d, hs_q, hs_d, vs_q, vs_d;

    // Line buffer
    logic [PIXEL_WIDTH-1:0] line_mem_q [LINE_SIZE_MAX];
    logic [PIXEL_WIDTH-1:0] prev_q;
    logic                   ram_en;
    logic [ADDR_W-1:0]      ram_addr;

    logic                   frame_start, line_start, take, in_range;
    logic                   pix_emit, pix_hs, pix_vs;
    logic [X_W-1:0]         pix_x;
    logic [DY_W-1:0]        pix_dy, dy_new;
    logic [POS_W-1:0]       line_pos, next_pos;
    logic [COE_WIDTH-1:0]   cprev1;
    logic [PROD_W-1:0]      prod_prev, prod_cur;
    logic [SUM_W-1:0]       shifted;

    // Next-state: frame/line tracking, emit decision and the three pipeline stages
    always_comb begin
        frame_start = de_i & hs_i & vs_i;
        line_start  = de_i & hs_i;
        take        = de_i & ((state_q == ACTIVE) | frame_start);

        state_d   = state_q;
        x_d       = x_q;
        line_d    = line_q;
        yo_d      = yo_q;
        step_d    = step_q;
        pending_d = pending_q;
        emit_d    = emit_q;
        dy_d      = dy_q;

        line_pos = {line_q, {STEP_LOG2{1'b0}}};
        next_pos = line_pos + STEP_POS;
        dy_new   = DY_W'(yo_q - line_pos);

        pix_x    = x_q;
        pix_emit = emit_q;
        pix_dy   = dy_q;
        pix_hs   = 1'b0;
        pix_vs   = 1'b0;

        if (take) begin
            if (frame_start) begin
                // A frame start always wins, even mid-line
                state_d   = ACTIVE;
                line_d    = '0;
                yo_d      = STEP_POS;
                step_d    = (v_scale_step < STEP_MIN) ? STEP_MIN : v_scale_step;
                pending_d = 1'b1;
                emit_d    = 1'b0;
                pix_emit  = 1'b0;
                pix_x     = '0;
            end else if (line_start) begin
                line_d = line_q + LINE_W'(1);
                pix_x  = '0;
                if (next_pos >= yo_q) begin
                    emit_d    = 1'b1;
                    dy_d      = dy_new;
                    yo_d      = yo_q + POS_W'(step_q);
                    pix_emit  = 1'b1;
                    pix_dy    = dy_new;
                    pix_hs    = 1'b1;
                    pix_vs    = pending_q;
                    pending_d = 1'b0;
                end else begin
                    emit_d   = 1'b0;
                    pix_emit = 1'b0;
                end
            end
        end

        in_range = (pix_x < X_LIMIT);
        ram_en   = take & in_range;
        ram_addr = pix_x[ADDR_W-1:0];
        if (take && in_range) begin
            x_d = pix_x + X_W'(1);
        end else if (take) begin
            x_d = pix_x;
        end

        v1_d    = take & in_range & pix_emit;
        hs1_d   = take & in_range & pix_hs;
        vs1_d   = take & in_range & pix_vs;
        cur1_d  = di_i;
        ccur1_d = take ? COE_WIDTH'(pix_dy >> COE_SHIFT) : ccur1_q;

        cprev1    = UNITY - ccur1_q;
        prod_prev = PROD_W'(cprev1) * PROD_W'(prev_q);
        prod_cur  = PROD_W'(ccur1_q) * PROD_W'(cur1_q);
        sum2_d    = SUM_W'(prod_prev) + SUM_W'(prod_cur) + ROUND;
        v2_d      = v1_q;
        hs2_d     = hs1_q;
        vs2_d     = vs1_q;

        shifted = sum2_q >> (COE_WIDTH - 1);
        do_d    = (shifted > SUM_W'(PIX_MAX)) ? PIX_MAX : shifted[PIXEL_WIDTH-1:0];
        de_d    = v2_q;
        hs_d    = hs2_q;
        vs_d    = vs2_q;
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_FRAME;
            x_q       <= '0;
            line_q    <= '0;
            yo_q      <= '0;
            step_q    <= '0;
            pending_q <= 1'b0;
            emit_q    <= 1'b0;
            dy_q      <= '0;
            v1_q      <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            cur1_q    <= '0;
            ccur1_q   <= '0;
            v2_q      <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            sum2_q    <= '0;
            do_q      <= '0;
            de_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            line_q    <= line_d;
            yo_q      <= yo_d;
            step_q    <= step_d;
            pending_q <= pending_d;
            emit_q    <= emit_d;
            dy_q      <= dy_d;
            v1_q      <= v1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            cur1_q    <= cur1_d;
            ccur1_q   <= ccur1_d;
            v2_q      <= v2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            sum2_q    <= sum2_d;
            do_q      <= do_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
        end
    end

    // Read-first line buffer: previous line read out while current line overwrites it
    always_ff @(posedge clk) begin
        if (ram_en) begin
            prev_q <= line_mem_q[ram_addr];
            line_mem_q[ram_addr] <= di_i;
        end
    end

    assign do_o = do_q;
    assign de_o = de_q;
    assign hs_o = hs_q;
    assign vs_o = vs_q;

endmodule

// File: tb/tb_scaler_linear_v.sv
// Directed bench for scaler_linear_v: frames of 4 lines x 8 pixels with
// hand-computed expected output lines, reset and restart scenarios.
module tb_scaler_linear_v;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   v_scale_step = 16'd4096;
    logic [PW-1:0] di_i = '0;
    logic          de_i = 1'b0;
    logic          hs_i = 1'b0;
    logic          vs_i = 1'b0;
    logic [PW-1:0] do_o;
    logic          de_o, hs_o, vs_o;

    scaler_linear_v #(
        .PIXEL_STEP   (4096),
        .PIXEL_WIDTH  (PW),
        .COE_WIDTH    (10),
        .LINE_SIZE_MAX(4096)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .v_scale_step(v_scale_step),
        .di_i        (di_i),
        .de_i        (de_i),
        .hs_i        (hs_i),
        .vs_i        (vs_i),
        .do_o        (do_o),
        .de_o        (de_o),
        .hs_o        (hs_o),
        .vs_o        (vs_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          val;
        int          hs;
        int          vs;
        int unsigned cyc;
    } out_t;

    out_t        got_q[$];
    out_t        exp_q[$];
    int unsigned hs_cyc_q[$];

    // Capture every valid output pixel away from the active edge
    always @(negedge clk) begin
        out_t o;
        if (de_o) begin
            o.val = int'(do_o);
            o.hs  = int'(hs_o);
            o.vs  = int'(vs_o);
            o.cyc = cyc;
            got_q.push_back(o);
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input bit de, input bit hs, input bit vs, input int val);
        @(posedge clk);
        #1;
        de_i = de;
        hs_i = hs;
        vs_i = vs;
        di_i = PW'(val);
        if (de && hs) hs_cyc_q.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic send_line(input int val, input bit fs);
        for (int p = 0; p < 8; p++) drive(1'b1, p == 0, fs && (p == 0), val);
        idle(2);
    endtask

    // Step only sampled at frame start; the mid-frame change must be ignored
    task automatic send_frame(input logic [15:0] step, input int v0, input int v1,
                              input int v2, input int v3);
        v_scale_step = step;
        send_line(v0, 1'b1);
        v_scale_step = 16'd8192;
        send_line(v1, 1'b0);
        send_line(v2, 1'b0);
        send_line(v3, 1'b0);
    endtask

    task automatic exp_line(input int val, input int n, input bit vs);
        out_t o;
        for (int i = 0; i < n; i++) begin
            o.val = val;
            o.hs  = (i == 0) ? 1 : 0;
            o.vs  = (i == 0 && vs) ? 1 : 0;
            o.cyc = 0;
            exp_q.push_back(o);
        end
    endtask

    task automatic compare_frame(input string name);
        int n;
        idle(8);
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_do[%0d]", name, i), got_q[i].val, exp_q[i].val);
            check($sformatf("%s_hs[%0d]", name, i), got_q[i].hs, exp_q[i].hs);
            check($sformatf("%s_vs[%0d]", name, i), got_q[i].vs, exp_q[i].vs);
        end
        $display("%s: %0d output pixels seen, %0d expected", name, got_q.size(), exp_q.size());
        got_q.delete();
        exp_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_do"}, int'(do_o), 0);
        check({name, "_de"}, int'(de_o), 0);
        check({name, "_hs"}, int'(hs_o), 0);
        check({name, "_vs"}, int'(vs_o), 0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Unity step: lines 1..3 emitted unchanged, plus latency of line 1 pixel 0
        send_frame(16'd4096, 100, 200, 300, 400);
        if (got_q.size() > 0 && hs_cyc_q.size() > 1)
            check("latency", int'(got_q[0].cyc - hs_cyc_q[1]), 3);
        else
            check("latency_missing", got_q.size(), 1);
        exp_line(200, 8, 1'b1);
        exp_line(300, 8, 1'b0);
        exp_line(400, 8, 1'b0);
        compare_frame("step4096");

        // 1.5x step: line 1, then half-way blend of lines 2 and 3
        send_frame(16'd6144, 100, 200, 300, 400);
        exp_line(200, 8, 1'b1);
        exp_line(350, 8, 1'b0);
        compare_frame("step6144");

        // Step below unity is treated as unity
        send_frame(16'd2048, 100, 200, 300, 400);
        exp_line(200, 8, 1'b1);
        exp_line(300, 8, 1'b0);
        exp_line(400, 8, 1'b0);
        compare_frame("step2048");

        // Full-scale input must not wrap after rounding
        send_frame(16'd6144, 4095, 4095, 4095, 4095);
        exp_line(4095, 8, 1'b1);
        exp_line(4095, 8, 1'b0);
        compare_frame("fullscale");

        // Reset pulse at line 2 pixel 3: nothing until the next frame start
        v_scale_step = 16'd4096;
        send_line(100, 1'b1);
        send_line(200, 1'b0);
        for (int p = 0; p < 4; p++) drive(1'b1, p == 0, 1'b0, 300);
        rst_n = 1'b0;
        got_q.delete();
        #2;
        check_outputs_zero("rst_mid");
        drive(1'b1, 1'b0, 1'b0, 300);
        drive(1'b1, 1'b0, 1'b0, 300);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 300);
        drive(1'b1, 1'b0, 1'b0, 300);
        idle(2);
        send_line(400, 1'b0);
        compare_frame("after_reset");
        send_frame(16'd4096, 100, 200, 300, 400);
        exp_line(200, 8, 1'b1);
        exp_line(300, 8, 1'b0);
        exp_line(400, 8, 1'b0);
        compare_frame("post_reset_frame");

        // Frame restart at line 2 pixel 4: in-flight pixels finish, new frame from its line 1
        v_scale_step = 16'd4096;
        send_line(100, 1'b1);
        send_line(200, 1'b0);
        for (int p = 0; p < 4; p++) drive(1'b1, p == 0, 1'b0, 300);
        drive(1'b1, 1'b1, 1'b1, 100);
        for (int p = 1; p < 8; p++) drive(1'b1, 1'b0, 1'b0, 100);
        idle(2);
        send_line(200, 1'b0);
        send_line(300, 1'b0);
        send_line(400, 1'b0);
        exp_line(200, 8, 1'b1);
        exp_line(300, 4, 1'b0);
        exp_line(200, 8, 1'b1);
        exp_line(300, 8, 1'b0);
        exp_line(400, 8, 1'b0);
        compare_frame("restart");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
